// File: rtl/xip_pkg.sv
// Shared constants and types for the XIP flash path (bus adapter and controller).
package xip_pkg;

  localparam logic [1:0] OP_READ         = 2'b00;
  localparam logic [1:0] OP_WRITE        = 2'b01;
  localparam logic [1:0] OP_SECTOR_ERASE = 2'b10;

  localparam int unsigned ERASE_ALIAS_BIT = 24;
  localparam int unsigned FLASH_ADDR_W    = 24;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } xip_state_e;

  // Flash byte at the lowest address is the MSB of the controller word.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/xip_word_cache.sv
// Direct-mapped one-word-per-line read cache indexed by flash word address.
module xip_word_cache
  import xip_pkg::*;
#(
  parameter int unsigned CACHE_LINES = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [FLASH_ADDR_W-1:2]   lookup_addr_i,
  output logic                      hit_o,
  output logic [31:0]               data_o,
  input  logic                      fill_i,
  input  logic [FLASH_ADDR_W-1:2]   fill_addr_i,
  input  logic [31:0]               fill_data_i,
  input  logic                      inv_all_i
);

  localparam int unsigned IdxW = $clog2(CACHE_LINES);
  localparam int unsigned TagW = FLASH_ADDR_W - 2 - IdxW;

  logic [CACHE_LINES-1:0] valid_q, valid_d;
  logic [TagW-1:0]        tag_q  [CACHE_LINES];
  logic [31:0]            data_q [CACHE_LINES];

  logic [IdxW-1:0] lk_idx, fl_idx;
  logic [TagW-1:0] lk_tag, fl_tag;

  assign lk_idx = lookup_addr_i[2 +: IdxW];
  assign lk_tag = lookup_addr_i[FLASH_ADDR_W-1 : 2+IdxW];
  assign fl_idx = fill_addr_i[2 +: IdxW];
  assign fl_tag = fill_addr_i[FLASH_ADDR_W-1 : 2+IdxW];

  assign hit_o  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign data_o = data_q[lk_idx];

  always_comb begin
    valid_d = valid_q;
    if (inv_all_i) begin
      valid_d = '0;
    end else if (fill_i) begin
      valid_d[fl_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/data need no reset: they are only observed through a valid bit.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[fl_idx]  <= fl_tag;
      data_q[fl_idx] <= fill_data_i;
    end
  end

endmodule

// File: rtl/xip_bus_adapter.sv
// Bus front end of the XIP path: req/gnt/rvalid to one-shot flash commands, with read cache.
module xip_bus_adapter
  import xip_pkg::*;
#(
  parameter int unsigned CACHE_LINES = 4,
  parameter bit          SWAP_BYTES  = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        ctrl_req_o,
  output logic [1:0]  ctrl_op_o,
  output logic [31:0] ctrl_addr_o,
  output logic [31:0] ctrl_wdata_o,
  input  logic        ctrl_valid_i,
  input  logic [31:0] ctrl_rdata_i
);

  xip_state_e state_q, state_d;
  logic [1:0]                    op_q, op_d;
  logic [FLASH_ADDR_W-1:2]       wa_q, wa_d;
  logic [31:0]                   wdata_q, wdata_d;
  logic [31:0]                   rdata_q, rdata_d;
  logic                          err_q, err_d;

  logic        hit;
  logic [31:0] hit_data;
  logic        fill, inv_all;
  logic [31:0] rd_bus;
  logic        alias_sel;

  // Upper address bits above the alias select and the byte offset carry no meaning here.
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:ERASE_ALIAS_BIT+1], addr_i[1:0]};

  assign alias_sel = addr_i[ERASE_ALIAS_BIT];
  assign rd_bus    = SWAP_BYTES ? bswap32(ctrl_rdata_i) : ctrl_rdata_i;

  xip_word_cache #(
    .CACHE_LINES (CACHE_LINES)
  ) u_cache (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .lookup_addr_i (addr_i[FLASH_ADDR_W-1:2]),
    .hit_o         (hit),
    .data_o        (hit_data),
    .fill_i        (fill),
    .fill_addr_i   (wa_q),
    .fill_data_i   (rd_bus),
    .inv_all_i     (inv_all)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wa_d    = wa_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    gnt_o   = 1'b0;
    fill    = 1'b0;
    inv_all = 1'b0;

    unique case (state_q)
      StIdle: begin
        gnt_o = req_i;
        if (req_i) begin
          wa_d    = addr_i[FLASH_ADDR_W-1:2];
          wdata_d = wdata_i;
          if (!we_i) begin
            if (alias_sel) begin
              rdata_d = '0;
              state_d = StResp;
            end else if (hit) begin
              rdata_d = hit_data;
              state_d = StResp;
            end else begin
              op_d    = OP_READ;
              state_d = StIssue;
            end
          end else if (alias_sel) begin
            op_d    = OP_SECTOR_ERASE;
            state_d = StIssue;
          end else if (be_i == 4'hF) begin
            op_d    = OP_WRITE;
            state_d = StIssue;
          end else begin
            // Partial-word programming is not supported by the flash path.
            err_d   = 1'b1;
            state_d = StResp;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (ctrl_valid_i) begin
          if (op_q == OP_READ) begin
            rdata_d = rd_bus;
            fill    = 1'b1;
          end else begin
            inv_all = 1'b1;
          end
          state_d = StResp;
        end
      end
      StResp: begin
        err_d   = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_q    <= OP_READ;
      wa_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wa_q    <= wa_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign rvalid_o     = (state_q == StResp);
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;
  assign ctrl_req_o   = (state_q == StIssue);
  assign ctrl_op_o    = op_q;
  assign ctrl_addr_o  = {{(32-FLASH_ADDR_W){1'b0}}, wa_q, 2'b00};
  assign ctrl_wdata_o = SWAP_BYTES ? bswap32(wdata_q) : wdata_q;

endmodule

// File: tb/tb_xip_bus_adapter.sv
// Directed and randomised bench for xip_bus_adapter against a transaction-level model.
module tb_xip_bus_adapter;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, err_o, ctrl_req_o;
  logic [31:0] rdata_o, ctrl_addr_o, ctrl_wdata_o;
  logic [1:0]  ctrl_op_o;
  logic        ctrl_valid_i;
  logic [31:0] ctrl_rdata_i;

  always #5 clk = ~clk;

  xip_bus_adapter #(
    .CACHE_LINES (4),
    .SWAP_BYTES  (1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_i        (req_i),
    .we_i         (we_i),
    .be_i         (be_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .ctrl_req_o   (ctrl_req_o),
    .ctrl_op_o    (ctrl_op_o),
    .ctrl_addr_o  (ctrl_addr_o),
    .ctrl_wdata_o (ctrl_wdata_o),
    .ctrl_valid_i (ctrl_valid_i),
    .ctrl_rdata_i (ctrl_rdata_i)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Model: 4-entry direct-mapped word cache keyed by word address.
  bit          mv [4];
  logic [19:0] mt [4];
  logic [31:0] md [4];

  int          exp_req_cyc = -1;
  int          exp_rv_cyc  = -1;
  logic [1:0]  exp_op;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  bit          exp_err;
  logic [31:0] model_rdata = '0;
  bit          busy = 1'b0;
  bit          done = 1'b0;
  int          rsp_lat = 1;
  logic [31:0] rsp_data = '0;

  int          nreq = 0;
  logic [1:0]  last_op;
  logic [31:0] last_addr, last_wdata;
  bit          last_err;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    busy        = 1'b0;
    exp_req_cyc = -1;
    exp_rv_cyc  = -1;
    model_rdata = '0;
  endtask

  task automatic txn_start(input bit we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] frd, input int lat,
                           input bit hold);
    int          idx;
    logic [19:0] tag;
    bit          issue;
    @(negedge clk);
    req_i = 1'b1; we_i = we; be_i = be; addr_i = addr; wdata_i = wd;
    rsp_lat = lat; rsp_data = frd; done = 1'b0;
    idx      = int'((addr >> 2) & 32'd3);
    tag      = addr[23:4];
    issue    = 1'b0;
    exp_err  = 1'b0;
    exp_rdata = model_rdata;
    exp_addr = {8'h00, addr[23:2], 2'b00};
    exp_wdata = swap(wd);
    if (!we) begin
      if (addr[24]) begin
        exp_rdata = '0;
      end else if (mv[idx] && mt[idx] == tag) begin
        exp_rdata = md[idx];
      end else begin
        issue = 1'b1; exp_op = 2'b00; exp_rdata = swap(frd);
        mv[idx] = 1'b1; mt[idx] = tag; md[idx] = swap(frd);
      end
    end else if (addr[24] || be == 4'hF) begin
      issue  = 1'b1;
      exp_op = addr[24] ? 2'b10 : 2'b01;
      for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    end else begin
      exp_err = 1'b1;
    end
    if (issue) begin
      exp_req_cyc = cyc + 1;
      exp_rv_cyc  = -1;
    end else begin
      exp_rv_cyc = cyc + 1;
    end
    @(posedge clk);
    busy = 1'b1;
    if (!hold) begin
      @(negedge clk);
      req_i = 1'b0;
    end
  endtask

  task automatic txn_wait();
    int t = 0;
    while (!done && t < 200) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("response_timeout", 32'(done), 32'd1);
  endtask

  task automatic txn(input bit we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [31:0] frd, input int lat);
    txn_start(we, be, addr, wd, frd, lat, 1'b0);
    txn_wait();
  endtask

  // Controller responder: completion pulse lat cycles after each command.
  initial begin
    int k;
    ctrl_valid_i = 1'b0;
    ctrl_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rst_ni && ctrl_req_o) begin
        k = 0;
        while (k < rsp_lat && rst_ni) begin
          @(negedge clk);
          k++;
        end
        if (rst_ni) begin
          ctrl_valid_i = 1'b1;
          ctrl_rdata_i = rsp_data;
          exp_rv_cyc   = cyc + 1;
          @(negedge clk);
          ctrl_valid_i = 1'b0;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    bit cur_err;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_ni) begin
        chk("rst_gnt", 32'(gnt_o), 32'd0);
        chk("rst_rvalid", 32'(rvalid_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_ctrl_req", 32'(ctrl_req_o), 32'd0);
        chk("rst_ctrl_op", 32'(ctrl_op_o), 32'd0);
        chk("rst_ctrl_addr", ctrl_addr_o, 32'd0);
        chk("rst_ctrl_wdata", ctrl_wdata_o, 32'd0);
      end else begin
        chk("gnt", 32'(gnt_o), 32'(req_i && !busy));
        chk("ctrl_req", 32'(ctrl_req_o), 32'(cyc == exp_req_cyc));
        if (ctrl_req_o) begin
          nreq++;
          last_op = ctrl_op_o; last_addr = ctrl_addr_o; last_wdata = ctrl_wdata_o;
          chk("ctrl_op", 32'(ctrl_op_o), 32'(exp_op));
          chk("ctrl_addr", ctrl_addr_o, exp_addr);
          if (exp_op == 2'b01) chk("ctrl_wdata", ctrl_wdata_o, exp_wdata);
        end
        chk("rvalid", 32'(rvalid_o), 32'(cyc == exp_rv_cyc));
        if (cyc == exp_rv_cyc) begin
          model_rdata = exp_rdata;
          cur_err     = exp_err;
          last_err    = err_o;
          busy        = 1'b0;
          done        = 1'b1;
        end else begin
          cur_err = 1'b0;
        end
        chk("rdata", rdata_o, model_rdata);
        chk("err", 32'(err_o), 32'(cur_err));
      end
    end
  end

  initial begin
    int          n0;
    logic [31:0] pool [8];
    logic [31:0] a;
    logic [3:0]  b;
    pool = '{32'h0000_0010, 32'h0000_0014, 32'h0000_0020, 32'h0000_0050,
             32'h0000_0110, 32'h0100_3000, 32'h0000_0034, 32'h0000_0013};
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;

    // Miss, then hit on the same word.
    n0 = nreq;
    txn(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h1122_3344, 2);
    chk("t1_nreq", 32'(nreq - n0), 32'd1);
    chk("t1_op", 32'(last_op), 32'd0);
    chk("t1_addr", last_addr, 32'h0000_0010);
    chk("t1_rdata", rdata_o, 32'h4433_2211);
    n0 = nreq;
    txn(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'hFFFF_FFFF, 2);
    chk("t2_nreq", 32'(nreq - n0), 32'd0);
    chk("t2_rdata", rdata_o, 32'h4433_2211);

    // Program invalidates, next read misses.
    txn(1'b1, 4'hF, 32'h0000_0010, 32'hA5A5_0001, 32'h0, 1);
    chk("t3_op", 32'(last_op), 32'd1);
    chk("t3_wdata", last_wdata, 32'h0100_A5A5);
    n0 = nreq;
    txn(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 3);
    chk("t3_refetch_nreq", 32'(nreq - n0), 32'd1);
    chk("t3_refetch_rdata", rdata_o, 32'hEFBE_ADDE);

    // Sector erase via alias, then the cached word misses again.
    txn(1'b1, 4'h1, 32'h0100_2000, 32'h0, 32'h0, 2);
    chk("t4_op", 32'(last_op), 32'd2);
    chk("t4_addr", last_addr, 32'h0000_2000);
    n0 = nreq;
    txn(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h0102_0304, 1);
    chk("t4_refetch_nreq", 32'(nreq - n0), 32'd1);

    // Partial write is rejected without flash access.
    n0 = nreq;
    txn(1'b1, 4'h3, 32'h0000_0020, 32'h1234_5678, 32'h0, 1);
    chk("t5_nreq", 32'(nreq - n0), 32'd0);
    chk("t5_err", 32'(last_err), 32'd1);
    chk("t5_rdata_held", rdata_o, 32'h0403_0201);

    // Stray completion while idle is ignored.
    @(negedge clk);
    ctrl_valid_i = 1'b1; ctrl_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    ctrl_valid_i = 1'b0;
    repeat (2) @(negedge clk);

    // Alias read returns zero.
    n0 = nreq;
    txn(1'b0, 4'hF, 32'h0100_0040, 32'h0, 32'h7777_7777, 1);
    chk("alias_rd_nreq", 32'(nreq - n0), 32'd0);
    chk("alias_rd_rdata", rdata_o, 32'h0);

    // Reset while waiting on the controller; cache must come back empty.
    txn(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h0A0B_0C0D, 1);
    txn_start(1'b0, 4'hF, 32'h0000_0030, 32'h0, 32'h5555_AAAA, 20, 1'b0);
    repeat (3) @(negedge clk);
    model_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    n0 = nreq;
    txn(1'b0, 4'hF, 32'h0000_0010, 32'h0, 32'h0A0B_0C0D, 2);
    chk("t6_post_reset_nreq", 32'(nreq - n0), 32'd1);
    chk("t6_rdata", rdata_o, 32'h0D0C_0B0A);

    // Back-to-back requests with req_i held high.
    for (int i = 0; i < 24; i++) begin
      a = pool[$urandom_range(0, 7)];
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      txn_start(1'($urandom_range(0, 1)), b, a, $urandom, $urandom, $urandom_range(1, 3), 1'b1);
      txn_wait();
    end
    @(negedge clk);
    req_i = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xip_bus_adapter.md
Name: xip_bus_adapter

Overview:
Bus-side front end of the XIP flash path. Accepts single-word requests from the core interconnect (req/gnt/rvalid handshake) and converts them into one-shot read / page-program / sector-erase commands for the W25Q64 XIP controller directly downstream. Contains a small direct-mapped read word cache, so repeated instruction fetches do not re-enter the slow SPI path. Also converts between bus little-endian words and the controller's MSB-first flash byte order.

Parameters:
CACHE_LINES, 4, number of one-word cache entries; power of two, minimum 2.
SWAP_BYTES, 1, 1 = byte-reverse data in both directions (flash byte at addr lands on bus bits [7:0]).

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
req_i  in  1  bus request
we_i  in  1  bus write enable
be_i  in  4  bus byte enables
addr_i  in  32  bus byte address; [23:0] flash offset, [24] erase-alias select
wdata_i  in  32  bus write data
gnt_o  out  1  request accepted (combinational)
rvalid_o  out  1  response valid, one-cycle pulse
rdata_o  out  32  response data
err_o  out  1  response error, qualified by rvalid_o
ctrl_req_o  out  1  command pulse to XIP controller
ctrl_op_o  out  2  00 read, 01 page program, 10 sector erase
ctrl_addr_o  out  32  {8'h0, flash offset}
ctrl_wdata_o  out  32  program data, flash byte order
ctrl_valid_i  in  1  controller completion pulse
ctrl_rdata_i  in  32  controller read data, flash byte order

Behaviour:
- Reset: gnt_o=0, rvalid_o=0, rdata_o=0, err_o=0, ctrl_req_o=0, ctrl_op_o=0, ctrl_addr_o=0, ctrl_wdata_o=0. FSM goes to S_IDLE. All cache valid bits are cleared.
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_RESP. One outstanding transaction at a time.
- S_IDLE: gnt_o = req_i. On grant in cycle T, latch we/be/addr/wdata. Low two address bits are ignored (word aligned).
  - Read, addr[24]=0, cache hit → S_RESP with the cached word; rvalid_o=1 in T+1.
  - Read, addr[24]=0, miss → S_ISSUE with op 00.
  - Read, addr[24]=1 → S_RESP, rdata 0, err 0.
  - Write, addr[24]=0, be=4'hF → S_ISSUE with op 01.
  - Write, addr[24]=1 (any be) → S_ISSUE with op 10. Sector address is addr[23:0]; the controller/flash ignores the low 12 bits.
  - Write, addr[24]=0, be≠4'hF → S_RESP, err_o=1; no flash access.
- S_ISSUE: ctrl_req_o=1 for exactly one cycle, ctrl_* fields driven from the latched values → S_WAIT. ctrl_req_o must never be held high: the controller re-samples req in its idle state.
- S_WAIT: hold until ctrl_valid_i. On that cycle:
  - Read: capture ctrl_rdata_i (byte-swapped if SWAP_BYTES) into rdata and fill the cache entry.
  - Program/erase: invalidate every cache entry.
  - Then → S_RESP.
- S_RESP: rvalid_o=1 for one cycle → S_IDLE. gnt_o=0 in every non-IDLE state.
- Latency:
  - Cache hit: rvalid at T+1.
  - Miss/write: ctrl_req_o at T+1, rvalid at the cycle after ctrl_valid_i.
- Cache:
  - Index = addr[2+:log2(CACHE_LINES)]; tag = addr[23:2+log2(CACHE_LINES)].
  - Entry = {valid, tag, data}, data stored in bus byte order.
  - Lookup is combinational in S_IDLE; fill/invalidate occur only in S_WAIT on ctrl_valid_i.
- rdata_o holds its last value between responses; err_o is 0 except in an error response.
- ctrl_valid_i outside S_WAIT is ignored.
- Reset mid-transaction: everything returns to reset state. The controller shares rst_ni, so no stale completion can arrive.

Decomposition:
- Package xip_pkg: OP_READ=2'b00, OP_WRITE=2'b01, OP_SECTOR_ERASE=2'b10, the FSM state enum, ERASE_ALIAS_BIT=24, FLASH_ADDR_W=24. The XIP controller imports the same op constants.
- Sub-module xip_word_cache (parameter CACHE_LINES). Ports: lookup addr → hit/data; fill (addr, data); invalidate_all.

Test Plan:
1. Read addr 0x0000_0010 with flash bytes 11 22 33 44 (ctrl_rdata_i=32'h11223344) → ctrl_req_o pulses once with op 00, addr 0x10; rdata_o=32'h44332211, err_o=0.
2. Repeat read of 0x10 → no ctrl_req_o; rvalid_o one cycle after gnt_o, same data.
3. Write 0x0000_0010, be=F, wdata 32'hA5A5_0001 → op 01, ctrl_wdata_o=32'h0100A5A5. Next read of 0x10 misses (ctrl_req_o seen again).
4. Write 0x0100_2000 → op 10, ctrl_addr_o=0x0000_2000; all entries invalidated.
5. Write 0x20 with be=4'h3 → rvalid_o with err_o=1; no ctrl_req_o.
6. Assert rst_ni low while in S_WAIT → all outputs 0. Post-reset read of a previously cached address issues ctrl_req_o (cache cleared). Random back-to-back req_i never sees gnt_o outside S_IDLE.
